// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: requester bus (req/value in; ack/ack_id/hundreds/tens/ones/busy out) of the shared BCD converter
interface bcd_conv_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] value;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    ack_id;
  logic [1:0]        hundreds;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic              busy;
  modport master (output req, value, input ack, ack_id, hundreds, tens, ones, busy);
  modport slave  (input req, value, output ack, ack_id, hundreds, tens, ones, busy);
endinterface

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: round-robin share of one binary_to_BCD among NREQ requesters; ports clk, rst, bus (bcd_conv_if.slave)
module binary_to_BCD (
  input  logic [7:0] bin,
  output logic [1:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  logic [17:0] s;
  always_comb begin
    s = {10'd0, bin};
    for (int i = 0; i < 8; i++) begin
      s[11:8]  = s[11:8]  >= 4'd5 ? s[11:8]  + 4'd3 : s[11:8];
      s[15:12] = s[15:12] >= 4'd5 ? s[15:12] + 4'd3 : s[15:12];
      s = s << 1;
    end
  end
  assign hundreds = s[17:16];
  assign tens     = s[15:12];
  assign ones     = s[11:8];
endmodule

module bcd_conv_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input logic       clk,
  input logic       rst,
  bcd_conv_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  logic [1:0]     st;
  logic [IDW-1:0] ptr, gid, sel;
  logic [7:0]     op;
  logic           hit;
  int             j;
  logic [1:0]     h;
  logic [3:0]     t, o;
  logic [7:0]     vals [NREQ];
  for (genvar g = 0; g < NREQ; g++) begin : g_vals
    assign vals[g] = bus.value[8*g +: 8];
  end
  always_comb begin
    sel = '0;
    hit = 1'b0;
    j   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (bus.req[IDW'(j)]) begin
        sel = IDW'(j);
        hit = 1'b1;
      end
    end
  end
  binary_to_BCD u_bcd (.bin(op), .hundreds(h), .tens(t), .ones(o));
  assign bus.busy = st == CONV || st == ACK;
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      ptr          <= '0;
      op           <= '0;
      gid          <= '0;
      bus.ack      <= '0;
      bus.ack_id   <= '0;
      bus.hundreds <= '0;
      bus.tens     <= '0;
      bus.ones     <= '0;
    end else begin
      case (st)
        IDLE: if (hit) begin
          op  <= vals[sel];
          gid <= sel;
          st  <= CONV;
        end
        CONV: begin
          bus.hundreds <= h;
          bus.tens     <= t;
          bus.ones     <= o;
          bus.ack_id   <= gid;
          bus.ack      <= NREQ'(1) << gid;
          st           <= ACK;
        end
        ACK: begin
          bus.ack <= '0;
          ptr     <= gid == IDW'(NREQ - 1) ? '0 : gid + 1'b1;
          st      <= IDLE;
        end
        default: begin
          bus.ack <= '0;
          st      <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// tb_bcd_conv_arbiter: randomized scoreboard bench for bcd_conv_arbiter
module tb_bcd_conv_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bcd_conv_if #(.NREQ(NREQ), .IDW(IDW)) bus ();
  bcd_conv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [NREQ-1:0] req_r = '0;
  logic [7:0]      val_r [NREQ];
  assign bus.req = req_r;
  for (genvar g = 0; g < NREQ; g++) begin : g_val
    assign bus.value[8*g +: 8] = val_r[g];
  end
  int vectors = 0;
  int miss = 0;
  int cyc = 0;
  logic [7:0]      sb [NREQ][$];
  int              ord [$];
  int              ack_cyc [$];
  logic [NREQ-1:0] prev_ack = '0;
  int              bvals [7] = '{0, 9, 10, 99, 100, 199, 200};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.ack != '0) begin
      ack_cyc.push_back(cyc);
      chk("ack_onehot", $countones(bus.ack), 1);
      chk("ack_single_cycle", int'(prev_ack), 0);
      chk("ack_id_matches_ack", int'(bus.ack), 1 << bus.ack_id);
      if (ord.size() > 0) begin
        chk("grant_order", int'(bus.ack_id), ord[0]);
        void'(ord.pop_front());
      end
      if (sb[bus.ack_id].size() == 0) begin
        vectors++;
        miss++;
        $display("FAIL unexpected_ack: requester %0d acked with nothing outstanding", bus.ack_id);
      end else begin
        chk("hundreds", int'(bus.hundreds), int'(sb[bus.ack_id][0]) / 100);
        chk("tens", int'(bus.tens), (int'(sb[bus.ack_id][0]) / 10) % 10);
        chk("ones", int'(bus.ones), int'(sb[bus.ack_id][0]) % 10);
        void'(sb[bus.ack_id].pop_front());
      end
    end
    prev_ack <= bus.ack;
  end
  task automatic do_req(input int i, input logic [7:0] v, input bit scr = 1'b0,
                        input int maxw = 3 * (NREQ - 1) + 2);
    int c0;
    int n;
    val_r[i] = v;
    req_r[i] = 1'b1;
    sb[i].push_back(v);
    c0 = cyc;
    if (scr) begin
      @(posedge clk);
      #1;
      if (bus.busy) val_r[i] = ~v;
    end
    n = 0;
    while (!bus.ack[i] && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!bus.ack[i]) begin
      miss++;
      $display("FAIL ack_timeout req%0d: no ack after %0d cycles, required within %0d", i, n, maxw);
      sb[i].delete();
    end else if (cyc - c0 < 2 || cyc - c0 > maxw) begin
      miss++;
      $display("FAIL req_to_ack req%0d: took %0d cycles, required 2..%0d", i, cyc - c0, maxw);
    end
    @(posedge clk);
    #1;
    req_r[i] = 1'b0;
  endtask
  task automatic rand_req(input int i);
    repeat (12) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      do_req(i, 8'($urandom_range(0, 255)));
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ack"}, int'(bus.ack), 0);
    chk({tag, "_ack_id"}, int'(bus.ack_id), 0);
    chk({tag, "_hundreds"}, int'(bus.hundreds), 0);
    chk({tag, "_tens"}, int'(bus.tens), 0);
    chk({tag, "_ones"}, int'(bus.ones), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < NREQ; i++) val_r[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_zero("reset");
    @(posedge clk);
    #1;
    ord.push_back(1);
    fork
      do_req(1, 8'd255);
      begin
        @(negedge clk);
        chk("single_busy_before_grant", int'(bus.busy), 0);
        @(negedge clk);
        chk("single_busy_after_grant", int'(bus.busy), 1);
        chk("single_ack_at_grant", int'(bus.ack), 0);
        @(negedge clk);
        chk("single_ack", int'(bus.ack), 4'b0010);
        chk("single_ack_id", int'(bus.ack_id), 1);
      end
    join
    foreach (bvals[k]) begin
      ord.push_back(0);
      do_req(0, 8'(bvals[k]));
    end
    do_reset();
    ack_cyc.delete();
    for (int i = 0; i < NREQ; i++) ord.push_back(i);
    fork
      do_req(0, 8'd12);
      do_req(1, 8'd34);
      do_req(2, 8'd56);
      do_req(3, 8'd78);
    join
    chk("four_acks", ack_cyc.size(), 4);
    for (int k = 0; k + 1 < ack_cyc.size(); k++) chk("ack_spacing", ack_cyc[k+1] - ack_cyc[k], 3);
    repeat (3) begin
      ord.push_back(0);
      ord.push_back(2);
    end
    fork
      repeat (3) do_req(0, 8'($urandom_range(0, 255)));
      repeat (3) do_req(2, 8'($urandom_range(0, 255)), 1'b0, 5);
    join
    fork
      rand_req(0);
      rand_req(1);
      rand_req(2);
      rand_req(3);
    join
    ord.push_back(3);
    fork
      do_req(3, 8'd200);
      begin
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_zero("midreset");
      end
    join
    for (int v = 0; v < 256; v++) do_req(2, 8'(v), 1'b1);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Shares one `binary_to_BCD` converter (8-bit binary in; 2-bit hundreds, 4-bit tens, 4-bit ones out) among NREQ requesters. Requesters include the display/score formatting logic and debug readout. The block arbitrates with a round-robin pointer, registers the granted operand, and registers the converter result. It then returns the result with a one-cycle acknowledge to the granted requester. It sits between the game/measurement logic and the 7-segment display drivers.

## Interface
- `NREQ`, default 4, number of requesters, 2..8.
- `IDW`, default 2, width of `ack_id`, equal to clog2(NREQ).
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NREQ  per-requester request level; bit i belongs to requester i.
- `value`  in  8*NREQ  operands; requester i drives `value[8*i+7:8*i]`.
- `ack`  out  NREQ  one-hot, one-cycle pulse to the requester being served.
- `ack_id`  out  IDW  index of the most recently served requester.
- `hundreds`  out  2  BCD hundreds of the last result.
- `tens`  out  4  BCD tens of the last result.
- `ones`  out  4  BCD ones of the last result.
- `busy`  out  1  high in CONV and ACK.

## Operation
- Internal state:
  - FSM with states IDLE, CONV, ACK.
  - Round-robin pointer `ptr` (IDW bits).
  - Operand register `op` (8 bits).
  - Grant register `gid` (IDW bits).
- The converter is a single instance of `binary_to_BCD`, driven only from `op`. It is never driven directly from `value`.
- IDLE:
  - If `req` is all zero, stay in IDLE.
  - Otherwise grant the first set bit searching `ptr`, `ptr+1`, … modulo NREQ.
  - Load `op` from that requester's `value` slice and load `gid`; go to CONV.
- CONV:
  - Register the converter outputs into `hundreds`/`tens`/`ones`; copy `gid` to `ack_id`.
  - Set `ack[gid]`=1; go to ACK.
- ACK:
  - Clear `ack`.
  - Set `ptr` to `gid+1` (wraps to 0 after NREQ-1); go to IDLE.
- Requester protocol:
  - Raise `req[i]` with `value` stable, and hold both until `ack[i]` is sampled high.
  - Requesters are registered, so `req[i]` drops on the same edge that ends ACK.
  - A `req[i]` still high in the following IDLE cycle is a new request.
- `value` is sampled only on the grant edge. Changes after that edge do not affect the result.
- Dropping `req[i]` before its grant withdraws the request cleanly. Dropping it after the grant edge does not cancel the conversion; the ack is still issued.
- Result outputs hold their value until the next CONV→ACK edge. `ack_id` tells the shared display drivers whose result they hold.
- Arithmetic:
  - Input range 0..255.
  - `hundreds` is 0..2; `tens` and `ones` are each 0..9.
  - hundreds*100 + tens*10 + ones = operand.
- Unused states (2-bit encoding value 3) go to IDLE on the next edge, with no ack.

## Timing
- Reset (`rst` high at an edge):
  - State becomes IDLE; `ptr`, `op`, `gid` become 0.
  - `ack` = 0, `ack_id` = 0, `hundreds` = `tens` = `ones` = 0, `busy` = 0.
- Reset mid-operation (in CONV or ACK) aborts the transaction: no ack is issued and the results return to 0. The requester keeps `req` high and is regranted after reset.
- Cycle numbering: E0 is the edge at which IDLE sees `req` set.
  - E0: grant, `op` latched, `busy` goes high.
  - E1: results and `ack_id` update, `ack` goes high.
  - E2: `ack` goes low, `busy` goes low, back in IDLE.
  - E3: earliest next grant.
- Throughput and latency:
  - Service period is 3 cycles per conversion.
  - Grant-to-ack latency is 1 cycle.
  - Worst-case wait from `req` high to grant is 3*(NREQ-1)+1 cycles, for a requester held continuously.
- Simultaneous requests: exactly one grant per IDLE cycle, decided by `ptr`. Other requesters wait with no loss.
- `ack` is never asserted for more than one cycle or to more than one requester.

## Test plan
- Single request, NREQ=4: `req[1]`=1 with value 255.
  - Ack timing: `ack`=0010 one edge after grant.
  - Result: hundreds=2, tens=5, ones=5, `ack_id`=1.
- Boundary values via requester 0, one at a time: 0, 9, 10, 99, 100, 199, 200 → BCD (0,0,0), (0,0,9), (0,1,0), (0,9,9), (1,0,0), (1,9,9), (2,0,0).
- All four requesters raise `req` together after reset, with values 12, 34, 56, 78.
  - Grants in order 0,1,2,3; acks 3 cycles apart.
  - Results 0/1/2, 0/3/4, 0/5/6, 0/7/8 respectively.
- Fairness: requester 0 re-requests immediately after every ack while requester 2 is held high.
  - Grants alternate 0,2,0,2.
  - Requester 2 never waits more than 4 cycles.
- Reset asserted in CONV for requester 3 (value 200):
  - No ack is issued; outputs stay 0.
  - After reset, with `req[3]` held, the conversion completes with hundreds=2, tens=0, ones=0.
- Exhaustive: requester 2 sweeps 0..255. Each ack is checked against operand/100, (operand/10)%10 and operand%10, and `value` changes after the grant edge must not alter the result.
